shifter_control_fsm: RTL and testbench

Sequencing controller that sits directly upstream of the 8-bit parallel-load shifter. It drives the shifter's two mode-select lines and its left and right fill bits. It runs one load cycle followed by a programmable number of shift cycles, and presents each bit leaving the shifter as a qualified serial stream. Its main use is as the transmit-side serializer for the shifter, with a start/busy/done handshake toward the issuing logic.

---
 rtl/shifter_control_fsm_if.sv | 32 +++
 rtl/shifter_control_fsm.sv | 133 +++++++++++++
 tb/tb_shifter_control_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/shifter_control_fsm_if.sv
// Handshake and shifter-control bundle between the issuing logic, the
// sequencing controller and the 8-bit parallel-load shifter.
interface shifter_control_fsm_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 4
);
    logic                 start_i;
    logic                 dir_i;
    logic                 fill_i;
    logic [CNT_WIDTH-1:0] shifts_i;
    logic [BUS_WIDTH-1:0] q_i;
    logic                 select1_o;
    logic                 select2_o;
    logic                 dataR_o;
    logic                 dataL_o;
    logic                 serial_o;
    logic                 serial_valid_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output start_i, dir_i, fill_i, shifts_i, q_i,
        input  select1_o, select2_o, dataR_o, dataL_o,
        input  serial_o, serial_valid_o, busy_o, done_o
    );

    modport slave (
        input  start_i, dir_i, fill_i, shifts_i, q_i,
        output select1_o, select2_o, dataR_o, dataL_o,
        output serial_o, serial_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/shifter_control_fsm.sv
// Load-then-shift sequencer for the parallel-load shifter; serializes the
// bit leaving the shifter each shift cycle with a start/busy/done handshake.
module shifter_control_fsm #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shifter_control_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT  = CNT_WIDTH'(BUS_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO_CNT = {CNT_WIDTH{1'b0}};

    state_t               state_q, state_d;
    logic                 dir_q,   dir_d;
    logic                 fill_q,  fill_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Requests longer than the shifter would only push fill bits out again.
    function automatic logic [CNT_WIDTH-1:0] sat_count(input logic [CNT_WIDTH-1:0] n);
        if (n > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return n;
        end
    endfunction

    // State and captured-parameter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            count_q <= ZERO_CNT;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; parameters are latched only when leaving IDLE.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    dir_d   = bus.dir_i;
                    fill_d  = bus.fill_i;
                    count_d = sat_count(bus.shifts_i);
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (count_q != ZERO_CNT) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                count_d = count_q - ONE_CNT;
                // A zero count here is unreachable; leave rather than wrap.
                if (count_q <= ONE_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; q_i feeds serial_o directly.
    always_comb begin
        bus.select1_o      = 1'b0;
        bus.select2_o      = 1'b0;
        bus.busy_o         = 1'b0;
        bus.done_o         = 1'b0;
        bus.serial_valid_o = 1'b0;
        bus.serial_o       = 1'b0;
        bus.dataR_o        = fill_q;
        bus.dataL_o        = fill_q;
        case (state_q)
            ST_IDLE: begin
                bus.busy_o = 1'b0;
            end
            ST_LOAD: begin
                bus.select2_o = 1'b1;
                bus.busy_o    = 1'b1;
            end
            ST_SHIFT: begin
                bus.select1_o      = 1'b1;
                bus.select2_o      = dir_q;
                bus.busy_o         = 1'b1;
                bus.serial_valid_o = 1'b1;
                if (dir_q) begin
                    bus.serial_o = bus.q_i[0];
                end else begin
                    bus.serial_o = bus.q_i[BUS_WIDTH-1];
                end
            end
            ST_DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
            end
            default: begin
                bus.busy_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shifter_control_fsm.sv
// Randomized bench: a behavioural shifter plant plus a transaction-level
// timeline model of the expected controller outputs.
module tb_shifter_control_fsm;

    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shifter_control_fsm_if #(.BUS_WIDTH(W), .CNT_WIDTH(C)) bus ();

    shifter_control_fsm #(.BUS_WIDTH(W), .CNT_WIDTH(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // stimulus
    logic         rst_v = 1'b0;
    logic         start_v = 1'b0, dir_v = 1'b0, fill_v = 1'b0;
    logic [C-1:0] shifts_v = '0;
    logic [W-1:0] data_v = '0;

    // shifter plant
    logic [W-1:0] sh_q = '0;
    logic [1:0]   code_s;
    logic         fr_s, fl_s;

    // reference: m_t = cycles since acceptance (-1 idle)
    int           m_t = -1;
    int           m_n = 0;
    logic         m_dir = 1'b0, m_fill = 1'b0;
    logic [W-1:0] m_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_outs();
        logic [1:0] code;
        logic b, d, v, s;
        code = 2'b00; b = 1'b0; d = 1'b0; v = 1'b0; s = 1'b0;
        if (m_t == 0) begin
            code = 2'b01; b = 1'b1;
        end else if (m_t >= 1 && m_t <= m_n) begin
            code = {1'b1, m_dir}; b = 1'b1; v = 1'b1;
            s = m_dir ? m_data[m_t-1] : m_data[W-m_t];
        end else if (m_t == m_n + 1) begin
            b = 1'b1; d = 1'b1;
        end
        return {code, b, d, v, s, m_fill, m_fill};
    endfunction

    // Final register image: fill bits enter from the vacated end.
    function automatic logic [W-1:0] exp_final();
        logic [2*W-1:0] t;
        if (!m_dir) begin
            t = {m_data, (m_fill ? 8'hFF : 8'h00)} << m_n;
            return t[2*W-1:W];
        end else begin
            t = {(m_fill ? 8'hFF : 8'h00), m_data} >> m_n;
            return t[W-1:0];
        end
    endfunction

    task automatic tick();
        logic [7:0] outs;
        @(negedge clk);
        rst_n        = rst_v;
        bus.start_i  = start_v;
        bus.dir_i    = dir_v;
        bus.fill_i   = fill_v;
        bus.shifts_i = shifts_v;
        #1;
        if (!rst_v) begin
            m_t = -1; m_dir = 1'b0; m_fill = 1'b0;
        end
        outs = {bus.select1_o, bus.select2_o, bus.busy_o, bus.done_o,
                bus.serial_valid_o, bus.serial_o, bus.dataR_o, bus.dataL_o};
        check(rst_v ? "outs" : "outs_in_reset", {24'd0, outs}, {24'd0, exp_outs()});
        code_s = {bus.select1_o, bus.select2_o};
        fr_s   = bus.dataR_o;
        fl_s   = bus.dataL_o;
        @(posedge clk);
        case (code_s)
            2'b01:   sh_q = data_v;
            2'b10:   sh_q = {sh_q[W-2:0], fr_s};
            2'b11:   sh_q = {fl_s, sh_q[W-1:1]};
            default: sh_q = sh_q;
        endcase
        if (rst_v) begin
            if (m_t < 0) begin
                if (start_v) begin
                    m_t = 0; m_dir = dir_v; m_fill = fill_v;
                    m_n = (int'(shifts_v) > W) ? W : int'(shifts_v);
                end
            end else if (m_t == 0) begin
                m_data = data_v;
                m_t = 1;
            end else if (m_t == m_n + 1) begin
                check("final_q", {24'd0, sh_q}, {24'd0, exp_final()});
                m_t = -1;
            end else begin
                m_t++;
            end
        end
        bus.q_i = sh_q;
    endtask

    task automatic run_seq(input logic [W-1:0] d, input logic dr, input logic f, input logic [C-1:0] n);
        int guard;
        data_v = d; dir_v = dr; fill_v = f; shifts_v = n; start_v = 1'b1;
        tick();
        start_v = 1'b0;
        guard = 0;
        while (m_t >= 0 && guard < 30) begin
            tick();
            guard++;
        end
        if (guard >= 30) check("timeout", 32'd1, 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.dir_i = 1'b0; bus.fill_i = 1'b0;
        bus.shifts_i = '0; bus.q_i = '0;
        rst_v = 1'b0;
        repeat (2) tick();
        rst_v = 1'b1;
        tick();

        run_seq(8'hA5, 1'b0, 1'b0, 4'd8);
        check("left_q", {24'd0, sh_q}, 32'h00);
        run_seq(8'h3C, 1'b1, 1'b1, 4'd3);
        check("right_q", {24'd0, sh_q}, 32'hE7);
        run_seq(8'h5A, 1'b0, 1'b1, 4'd0);
        run_seq(8'hC3, 1'b1, 1'b0, 4'd15);

        // start/dir/fill churn while a sequence is running
        data_v = 8'h96; dir_v = 1'b0; fill_v = 1'b1; shifts_v = 4'd6; start_v = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            start_v  = (m_t >= 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            dir_v    = 1'($urandom_range(0, 1));
            fill_v   = 1'($urandom_range(0, 1));
            shifts_v = C'($urandom_range(0, 15));
            tick();
        end
        start_v = 1'b0;
        repeat (2) tick();

        // back-to-back with start held high
        data_v = 8'h81; dir_v = 1'b1; fill_v = 1'b0; shifts_v = 4'd2; start_v = 1'b1;
        repeat (25) tick();
        start_v = 1'b0;
        repeat (6) tick();

        // asynchronous reset in the middle of a shift run
        data_v = 8'hF0; dir_v = 1'b0; fill_v = 1'b1; shifts_v = 4'd8; start_v = 1'b1;
        tick();
        start_v = 1'b0;
        repeat (4) tick();
        rst_v = 1'b0;
        repeat (2) tick();
        rst_v = 1'b1;
        repeat (2) tick();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            start_v  = ($urandom_range(0, 2) == 0);
            dir_v    = 1'($urandom_range(0, 1));
            fill_v   = 1'($urandom_range(0, 1));
            shifts_v = C'($urandom_range(0, 15));
            data_v   = W'($urandom);
            tick();
        end
        start_v = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
